// File: rtl/vfd_shiftreg_pkg.sv
// Shared types and helpers for the burst shift register: controller states,
// shift direction encoding and burst-length clamping.
package vfd_shiftreg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

  // Requests longer than the register are clipped to a full-width burst.
  function automatic int unsigned clamp_count(int unsigned cnt, int unsigned max_cnt);
    return (cnt > max_cnt) ? max_cnt : cnt;
  endfunction

endpackage

// File: rtl/vfd_shiftreg_core.sv
// Datapath: WIDTH-bit register with parallel load and one-bit shift in either
// direction; serial_o keeps the last bit shifted out.
module vfd_shiftreg_core
  import vfd_shiftreg_pkg::*;
#(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             shift_i,
  input  logic             dir_i,
  input  logic             serial_i,
  output logic [WIDTH-1:0] result_o,
  output logic             serial_o
);

  logic [WIDTH-1:0] r_q, r_d;
  logic             ser_q, ser_d;

  always_comb begin
    r_d   = r_q;
    ser_d = ser_q;
    if (load_i) begin
      r_d = data_i;
    end else if (shift_i) begin
      if (dir_i == DIR_LEFT) begin
        r_d   = {r_q[WIDTH-2:0], serial_i};
        ser_d = r_q[WIDTH-1];
      end else begin
        r_d   = {serial_i, r_q[WIDTH-1:1]};
        ser_d = r_q[0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q   <= '0;
      ser_q <= 1'b0;
    end else begin
      r_q   <= r_d;
      ser_q <= ser_d;
    end
  end

  assign result_o = r_q;
  assign serial_o = ser_q;

endmodule

// File: rtl/vfd_shiftreg_burst.sv
// Burst shift register top: IDLE/SHIFT/DONE controller with a latched burst
// count and direction, driving the shift datapath.
module vfd_shiftreg_burst
  import vfd_shiftreg_pkg::*;
#(
  parameter  int WIDTH = 5,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_enable,
  input  logic             i_start,
  input  logic [CNT_W-1:0] i_count,
  input  logic             i_dir,
  input  logic             i_serial,
  output logic [WIDTH-1:0] o_result,
  output logic             o_serial,
  output logic             o_busy,
  output logic             o_done
);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             dir_q;

  logic             is_idle, is_shift;
  logic             core_load, core_shift, core_dir;
  logic [CNT_W-1:0] start_cnt;

  assign is_idle   = (state_q == ST_IDLE);
  assign is_shift  = (state_q == ST_SHIFT);
  assign start_cnt = CNT_W'(clamp_count(32'(i_count), WIDTH));

  // Requests only count in IDLE; a burst uses the direction latched at start.
  assign core_load  = is_idle & i_load;
  assign core_shift = (is_idle & ~i_load & ~i_start & i_enable) | is_shift;
  assign core_dir   = is_shift ? dir_q : i_dir;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      dir_q   <= DIR_RIGHT;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!i_load && i_start) begin
            cnt_q   <= start_cnt;
            dir_q   <= i_dir;
            state_q <= (start_cnt == '0) ? ST_DONE : ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_q <= ST_DONE;
        end
        ST_DONE:  state_q <= ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_busy = ~is_idle;
  assign o_done = (state_q == ST_DONE);

  vfd_shiftreg_core #(.WIDTH(WIDTH)) u_core (
    .clk      (clk),
    .rst      (rst),
    .load_i   (core_load),
    .data_i   (i_data),
    .shift_i  (core_shift),
    .dir_i    (core_dir),
    .serial_i (i_serial),
    .result_o (o_result),
    .serial_o (o_serial)
  );

endmodule
